// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder for the serial even-ones detector, with a one-word holding buffer.
// Define PARITY_BIT_EN to append an even-parity bit after the data bits of every word.
module piso_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    typedef logic [CntW-1:0] cnt_t;

`ifdef PARITY_BIT_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q;
    cnt_t             bit_cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
`ifdef PARITY_BIT_EN
    logic             par_q;
`endif

    logic             accept;
    logic             data_end;
    logic             word_end;
    logic             free;
    logic             start;
    logic             load_hold;
    logic [WIDTH-1:0] start_word;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign din_ready = !rst && !hold_full_q;
    assign accept    = din_valid && din_ready;
    assign data_end  = (state_q == StShift) && (bit_cnt_q == cnt_t'(WIDTH - 1));
`ifdef PARITY_BIT_EN
    assign word_end  = (state_q == StPar);
`else
    assign word_end  = data_end;
`endif
    // free: the edge at the end of this cycle may load the shift register
    assign free       = (state_q == StIdle) || word_end;
    assign start      = free && (hold_full_q || accept);
    assign start_word = hold_full_q ? hold_q : din;
    assign load_hold  = accept && !free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef PARITY_BIT_EN
            par_q       <= 1'b0;
`endif
            x           <= 1'b0;
            x_valid     <= 1'b0;
            last        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (load_hold) begin
                hold_q      <= din;
                hold_full_q <= 1'b1;
            end
            if (start) begin
                // Held word takes priority; din_ready is low whenever hold is full
                if (hold_full_q) begin
                    hold_full_q <= 1'b0;
                end
                state_q   <= StShift;
                bit_cnt_q <= '0;
                sr_q      <= advance(start_word);
`ifdef PARITY_BIT_EN
                par_q     <= ^start_word;
`endif
                x         <= head_bit(start_word);
                x_valid   <= 1'b1;
                last      <= 1'b0;
                busy      <= 1'b1;
            end else if (free) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                x         <= 1'b0;
                x_valid   <= 1'b0;
                last      <= 1'b0;
                busy      <= 1'b0;
            end
`ifdef PARITY_BIT_EN
            else if (data_end) begin
                state_q <= StPar;
                x       <= par_q;
                last    <= 1'b1;
            end
`endif
            else begin
                bit_cnt_q <= bit_cnt_q + cnt_t'(1);
                sr_q      <= advance(sr_q);
                x         <= head_bit(sr_q);
`ifdef PARITY_BIT_EN
                last      <= 1'b0;
`else
                last      <= (bit_cnt_q == cnt_t'(WIDTH - 2));
`endif
            end
        end
    end

endmodule

// File: doc/piso_bit_feeder.md
Name: piso_bit_feeder

Overview:
Parallel-in/serial-out feeder that sits directly upstream of the serial even-ones detector and drives its 1-bit input `x`. It accepts WIDTH-bit words over a valid/ready handshake. Each word is shifted out one bit per clock, with a one-entry holding buffer so back-to-back words stream with no idle cycle. A `last` flag marks word boundaries so downstream logic can sample the detector output per word.

Parameters:
WIDTH, 8, data word width in bits (must be >= 2)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 shifted first

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  WIDTH  parallel word to serialise
din_valid  input  1  din holds a valid word
din_ready  output  1  feeder can accept a word this cycle
x  output  1  serial bit to detector (registered)
x_valid  output  1  x carries a real data bit this cycle
last  output  1  current x is the final bit of its word
busy  output  1  shift register or holding buffer occupied

Behaviour:
- Clocking: one clock, clk. Reset: rst, synchronous, active-high. All outputs are registered except din_ready.
- While rst is high, at each edge:
  - x=0, x_valid=0, last=0, busy=0.
  - Shift register, holding buffer and bit counter are cleared; FSM goes to IDLE.
  - din_ready is forced 0 while rst is high.
- din_ready = !rst && !hold_full.
- A handshake occurs at an edge where din_valid && din_ready.
- Load target for an accepted word:
  - Goes to the shift register if FSM is IDLE, or if the current x is the last bit and the holding buffer is empty.
  - Otherwise goes to the holding buffer, which sets hold_full.
- FSM states:
  - IDLE: x_valid=0, x=0. On a handshake, load the shift register, bit_cnt=0, go to SHIFT.
  - SHIFT: each edge presents the next bit on x with x_valid=1; bit_cnt increments. The bit with bit_cnt==WIDTH-1 is the last data bit.
  - At the edge ending the last bit:
    - If hold_full: hold moves to the shift register, hold_full clears, stay in SHIFT with bit_cnt=0 (zero bubble).
    - Else if a handshake occurs at the same edge: load din directly, stay in SHIFT.
    - Otherwise go to IDLE.
- Latency: word accepted at edge N puts its first bit on x in the cycle after edge N. That word occupies exactly WIDTH consecutive x_valid cycles.
- Bit order:
  - MSB_FIRST=1: din[WIDTH-1] down to din[0].
  - MSB_FIRST=0: din[0] up to din[WIDTH-1].
- last=1 only during the final serial bit of each word (data bit, or parity bit when enabled).
- busy = (state != IDLE) || hold_full.
- bit_cnt width is $clog2(WIDTH+1). It never wraps beyond the final-bit index.
- din is sampled only on a handshake. Changes to din while din_ready=0 are ignored.
- Reset mid-word: the partially shifted word and any held word are discarded. x_valid=0 in the cycle after the reset edge, and no residual bits are emitted.

Optional Feature:
Macro PARITY_BIT_EN.
- Defined:
  - Adds state PAR after the last data bit of each word.
  - x = XOR of the word's data bits (even parity: total ones across data+parity is even), x_valid=1, last=1 on this bit.
  - The last-data-bit cycle has last=0.
  - Holding-buffer promotion and direct load occur at the edge ending PAR instead of the last data bit.
  - Each word takes WIDTH+1 cycles.
- Undefined: no PAR state, WIDTH cycles per word, last on the final data bit.

Test Plan:
1. Reset: rst=1 for 2 cycles with din_valid=1 -> x=0, x_valid=0, last=0, busy=0, din_ready=0 throughout; din_ready=1 in the first cycle after rst falls.
2. Single word (WIDTH=8, MSB_FIRST=1): din=8'hA5 accepted.
   -> x=1,0,1,0,0,1,0,1 over the next 8 cycles, x_valid=1 on all 8.
   -> last=1 only on the 8th; x_valid=0 and busy=0 on the 9th.
3. Back-to-back: 8'h0F then 8'hF0 offered on consecutive cycles.
   -> 16 contiguous x_valid cycles, x=0000111111110000.
   -> din_ready=0 from after the second accept until the edge ending bit 8 of the first word; last on cycles 8 and 16.
4. LSB first: MSB_FIRST=0, din=8'h01.
   -> x=1,0,0,0,0,0,0,0, last on the 8th bit.
5. Reset mid-word: accept 8'hFF, load 8'h81 into hold, assert rst after 3 bits.
   -> x_valid=0 from the next cycle; 8'h81 never emitted; din_ready=1 after rst deasserts.
6. PARITY_BIT_EN with din=8'h07 (MSB first).
   -> x=0,0,0,0,0,1,1,1,1 over 9 x_valid cycles; last only on the 9th (parity=1).
   -> Downstream even-ones detector reports even at the word end.
